// File: rtl/gate_arb_pkg.sv
// Shared definitions for the gate arbiter: op codes and FSM state encoding.
package gate_arb_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/gate_arbiter_bitwise_unit.sv
// Combinational bitwise logic unit shared by all requesters of the gate arbiter.
module bitwise_unit
   import gate_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // Select the requested bitwise function of the two operands.
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one registered bitwise unit among NUM_REQ requesters.
// Each transaction runs accept (IDLE) -> execute (EXEC) -> respond (RESP).
module gate_arbiter
   import gate_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned WIDTH   = 8,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*2-1:0]     req_op,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH-1:0]         resp_data,
   output logic [ID_W-1:0]          resp_id,
   output logic                     busy
);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  result_q, result_d;

   logic [WIDTH-1:0]  a_arr  [NUM_REQ];
   logic [WIDTH-1:0]  b_arr  [NUM_REQ];
   logic [1:0]        op_arr [NUM_REQ];

   logic              found;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   idx;
   logic [WIDTH-1:0]  unit_y;

   // Unpack the flat requester buses into per-requester arrays.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         a_arr[i]  = req_a[i*WIDTH +: WIDTH];
         b_arr[i]  = req_b[i*WIDTH +: WIDTH];
         op_arr[i] = req_op[i*2 +: 2];
      end
   end

   // Round-robin search starting at rr_ptr; index wraps naturally since NUM_REQ is a power of two.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = rr_ptr_q + ID_W'(k);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   bitwise_unit #(
      .WIDTH (WIDTH)
   ) u_unit (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (unit_y)
   );

   // Next-state, grant and capture logic for the accept/execute/respond sequence.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      id_d      = id_q;
      result_d  = result_q;
      req_ready = '0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               req_ready[winner] = 1'b1;
               a_d      = a_arr[winner];
               b_d      = b_arr[winner];
               op_d     = op_arr[winner];
               id_d     = winner;
               rr_ptr_d = winner + ID_W'(1);
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = unit_y;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         id_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         id_q     <= id_d;
         result_q <= result_d;
      end
   end

   assign resp_valid = (state_q == ST_RESP);
   assign busy       = (state_q != ST_IDLE);
   assign resp_data  = result_q;
   assign resp_id    = id_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter with a cycle reference model and a result scoreboard.
module tb_gate_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [7:0]  req_op;
   logic        resp_valid;
   logic        resp_ready;
   logic [7:0]  resp_data;
   logic [1:0]  resp_id;
   logic        busy;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   obs_grants[$];
   int   n_cmp;
   int   n_err;
   int   m_state;
   int   m_rr;
   bit   rec_en;

   gate_arbiter #(
      .NUM_REQ (4),
      .WIDTH   (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] ref_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
      req_op[i*2 +: 2] = op;
   endtask

   // One clock cycle: called just after a falling edge with inputs already driven.
   task automatic cycle();
      logic [3:0] exp_ready;
      int         w;
      exp_t       e;
      #1;
      exp_ready = '0;
      w = -1;
      if (m_state == 0) begin
         for (int k = 0; k < 4; k++) begin
            if (w < 0 && req_valid[(m_rr + k) % 4]) w = (m_rr + k) % 4;
         end
      end
      if (w >= 0) exp_ready[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("resp_valid", 32'(resp_valid), 32'(m_state == 2));
      if (m_state == 2) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
         end else begin
            chk("resp_data", 32'(resp_data), 32'(exp_q[0].data));
            chk("resp_id", 32'(resp_id), 32'(exp_q[0].id));
         end
      end
      if (rec_en && ((req_ready & req_valid) != 4'b0)) begin
         for (int i = 0; i < 4; i++) if (req_ready[i]) obs_grants.push_back(i);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_state = 0;
         m_rr    = 0;
         exp_q.delete();
      end else begin
         case (m_state)
            0: if (w >= 0) begin
                  e.id   = 2'(w);
                  e.data = ref_f(req_op[w*2 +: 2], req_a[w*8 +: 8], req_b[w*8 +: 8]);
                  exp_q.push_back(e);
                  m_rr    = (w + 1) % 4;
                  m_state = 1;
               end
            1: m_state = 2;
            default: if (resp_ready) begin
                  void'(exp_q.pop_front());
                  m_state = 0;
               end
         endcase
      end
      @(negedge clk);
   endtask

   task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] exp);
      set_req(i, a, b, op);
      req_valid = 4'b0;
      req_valid[i] = 1'b1;
      cycle();
      req_valid = 4'b0;
      cycle();
      chk("op_result", 32'(resp_data), 32'(exp));
      cycle();
   endtask

   initial begin
      int exp_g[4];
      clk = 1'b0;
      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      req_op = '0;
      resp_ready = 1'b1;
      n_cmp = 0;
      n_err = 0;
      m_state = 0;
      m_rr = 0;
      rec_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cycle();
      chk("rst_resp_data", 32'(resp_data), 32'h0);
      chk("rst_resp_id", 32'(resp_id), 32'h0);
      rst_n = 1'b1;

      // Single op on requester 2
      run_op(2, 8'hF0, 8'h3C, 2'b00, 8'h30);
      chk("single_id", 32'(resp_id), 32'd2);

      // Op coverage on requester 1
      run_op(1, 8'hAA, 8'h0F, 2'b00, 8'h0A);
      run_op(1, 8'hAA, 8'h0F, 2'b01, 8'hAF);
      run_op(1, 8'hAA, 8'h0F, 2'b10, 8'hA5);
      run_op(1, 8'hAA, 8'h0F, 2'b11, 8'hF5);

      // Fairness from reset with all requesters pending
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      set_req(0, 8'h11, 8'hFF, 2'b00);
      set_req(1, 8'h22, 8'h01, 2'b01);
      set_req(2, 8'h33, 8'h0F, 2'b10);
      set_req(3, 8'h44, 8'h0C, 2'b11);
      req_valid = 4'hF;
      rec_en = 1'b1;
      repeat (12) cycle();
      exp_g = '{0, 1, 2, 3};
      chk("fair_count", 32'(obs_grants.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs_grants.size(); i++) chk("fair_order", 32'(obs_grants[i]), 32'(exp_g[i]));

      // Wrap after grant to 3
      obs_grants.delete();
      req_valid = 4'b1001;
      repeat (6) cycle();
      chk("wrap_count", 32'(obs_grants.size()), 32'd2);
      if (obs_grants.size() == 2) begin
         chk("wrap_first", 32'(obs_grants[0]), 32'd0);
         chk("wrap_second", 32'(obs_grants[1]), 32'd3);
      end
      rec_en = 1'b0;
      req_valid = 4'b0;
      repeat (2) cycle();

      // Backpressure in RESP with requests pending meanwhile
      set_req(2, 8'h5A, 8'hFF, 2'b10);
      req_valid = 4'b0100;
      cycle();
      req_valid = 4'hF;
      resp_ready = 1'b0;
      cycle();
      repeat (5) cycle();
      chk("bp_data", 32'(resp_data), 32'hA5);
      resp_ready = 1'b1;
      cycle();
      cycle();
      req_valid = 4'b0;
      repeat (3) cycle();

      // Reset during EXEC
      req_valid = 4'hF;
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      #1;
      chk("exec_rst_busy", 32'(busy), 32'd0);
      chk("exec_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("exec_rst_grant", 32'(req_ready), 32'h1);
      chk("exec_rst_resp_data", 32'(resp_data), 32'h0);
      cycle();
      req_valid = 4'b0;
      repeat (3) cycle();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
